// File: rtl/startup_disp_pkg.sv
// Shared types and constants for the startup pattern display: shifter states,
// the sequencer dwell count and the frame-length arithmetic.
package startup_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } shift_state_e;

  localparam logic [15:0] WAIT_CNT = 16'hBB8;
  localparam logic [15:0] TMR_MAX  = 16'hFFFF;

  // CLK cycles from frame capture until BUSY drops: PAT_W SCLK periods plus the latch strobe.
  function automatic int unsigned frame_len(input int unsigned pat_w, input int unsigned div);
    return pat_w * 2 * div + div;
  endfunction

endpackage

// File: rtl/startup_pattern_display_if.sv
// Sequencer-side control/status bundle plus the LED chain pins of the pattern display.
// The sequencer (or bench) uses master; the display block uses slave.
interface startup_pattern_display_if;
  logic        clear;
  logic        disp;
  logic        load_pat;
  logic        nxt_adr;
  logic        rst_tmr;
  logic [15:0] tmr;
  logic        done;
  logic        busy;
  logic        overrun;
  logic        led_sclk;
  logic        led_sdat;
  logic        led_latch;
  logic        led_oe_b;

  modport master (
    output clear, disp, load_pat, nxt_adr, rst_tmr,
    input  tmr, done, busy, overrun, led_sclk, led_sdat, led_latch, led_oe_b
  );

  modport slave (
    input  clear, disp, load_pat, nxt_adr, rst_tmr,
    output tmr, done, busy, overrun, led_sclk, led_sdat, led_latch, led_oe_b
  );
endinterface

// File: rtl/startup_pattern_rom.sv
// Startup LED pattern table, synchronous read with 1 CLK latency; no backpressure.
// Address 0 is the blank pattern; unused addresses read as blank too.
module startup_pattern_rom
  import startup_disp_pkg::*;
#(
  parameter int PAT_W = 16,
  parameter int ADR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] adr,
  output logic [PAT_W-1:0] dat
);

  logic [PAT_W-1:0] dat_d;
  logic [PAT_W-1:0] dat_q;

  always_comb begin
    dat_d = '0;
    case (adr)
      ADR_W'(1): dat_d = PAT_W'(16'hA5C3);
      ADR_W'(2): dat_d = PAT_W'(16'h0F0F);
      ADR_W'(3): dat_d = PAT_W'(16'hF00F);
      ADR_W'(4): dat_d = PAT_W'(16'h3C3C);
      ADR_W'(5): dat_d = PAT_W'(16'h8001);
      ADR_W'(6): dat_d = PAT_W'(16'hFFFF);
      ADR_W'(7): dat_d = PAT_W'(16'h5A5A);
      ADR_W'(8): dat_d = PAT_W'(16'h1234);
      default:   dat_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dat_q <= '0;
    else     dat_q <= dat_d;
  end

  assign dat = dat_q;

endmodule

// File: rtl/startup_pattern_display.sv
// Wait timer, pattern address/DONE and a serial LED frame shifter; all outputs registered.
// A frame takes PAT_W*2*DIV+DIV CLK; LOAD_PAT during a frame is dropped and flagged in OVERRUN.
module startup_pattern_display
  import startup_disp_pkg::*;
#(
  parameter int PAT_W = 16,
  parameter int NPAT  = 8,
  parameter int ADR_W = 4,
  parameter int DIV   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  startup_pattern_display_if.slave bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(NPAT);

  if (frame_len(PAT_W, DIV) >= 32'(WAIT_CNT)) begin : g_frame_too_long
    $error("LED frame of %0d CLK does not fit in the sequencer dwell", frame_len(PAT_W, DIV));
  end
  if ((2 ** ADR_W) <= NPAT || DIV < 1 || PAT_W < 2) begin : g_bad_param
    $error("startup_pattern_display: illegal parameter combination");
  end

  logic [15:0]      tmr_q, tmr_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             done_q, done_d;
  logic             oe_b_q, oe_b_d;
  logic             clear_q, clear_d;
  shift_state_e     state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             sclk_q, sclk_d;
  logic             sdat_q, sdat_d;
  logic             latch_q, latch_d;

  logic [PAT_W-1:0] rom_dat;
  logic [PAT_W-1:0] frame;
  logic             clr_rise;
  logic             div_last;

  startup_pattern_rom #(
    .PAT_W (PAT_W),
    .ADR_W (ADR_W)
  ) u_rom (
    .clk (clk),
    .rst (rst),
    .adr (adr_q),
    .dat (rom_dat)
  );

  always_comb begin
    tmr_d = tmr_q;
    if (bus.rst_tmr)         tmr_d = '0;
    else if (tmr_q != TMR_MAX) tmr_d = tmr_q + 16'd1;

    adr_d = adr_q;
    if (bus.clear)                              adr_d = '0;
    else if (bus.nxt_adr && adr_q != ADR_LAST)  adr_d = adr_q + ADR_W'(1);

    // DONE trails ADR by one CLK so it is settled before the sequencer's LOAD_PAT.
    done_d  = (adr_q == ADR_LAST);
    oe_b_d  = ~bus.disp;
    clear_d = bus.clear;
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    sdat_d    = sdat_q;
    latch_d   = latch_q;
    overrun_d = overrun_q | (bus.load_pat & busy_q);
    clr_rise  = bus.clear & ~clear_q;
    div_last  = (div_cnt_q == DIV_LAST);
    frame     = clr_rise ? '0 : rom_dat;

    // A CLEAR edge preempts any frame in flight with a blank one.
    if (clr_rise || (state_q == IDLE && bus.load_pat && !bus.clear)) begin
      state_d   = SHIFT;
      shreg_d   = frame;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sclk_d    = 1'b0;
      sdat_d    = frame[PAT_W-1];
      latch_d   = 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          div_cnt_d = div_last ? '0 : div_cnt_q + CNT_W'(1);
          if (div_last) begin
            if (!sclk_q) begin
              sclk_d = 1'b1;
            end else begin
              sclk_d = 1'b0;
              if (bit_cnt_q == BIT_LAST) begin
                state_d = LATCH;
                latch_d = 1'b1;
                sdat_d  = 1'b0;
              end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                shreg_d   = shreg_q << 1;
                sdat_d    = shreg_q[PAT_W-2];
              end
            end
          end
        end
        LATCH: begin
          div_cnt_d = div_last ? '0 : div_cnt_q + CNT_W'(1);
          if (div_last) begin
            state_d = IDLE;
            latch_d = 1'b0;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q     <= '0;
      adr_q     <= '0;
      done_q    <= 1'b0;
      oe_b_q    <= 1'b1;
      clear_q   <= 1'b0;
      state_q   <= IDLE;
      shreg_q   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      sclk_q    <= 1'b0;
      sdat_q    <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      adr_q     <= adr_d;
      done_q    <= done_d;
      oe_b_q    <= oe_b_d;
      clear_q   <= clear_d;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      sclk_q    <= sclk_d;
      sdat_q    <= sdat_d;
      latch_q   <= latch_d;
    end
  end

  assign bus.tmr       = tmr_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.led_sclk  = sclk_q;
  assign bus.led_sdat  = sdat_q;
  assign bus.led_latch = latch_q;
  assign bus.led_oe_b  = oe_b_q;

endmodule

// File: tb/tb_startup_pattern_display.sv
// Bench for startup_pattern_display: frames expected by a cycle-level model are queued and
// a separate LED-chain monitor pops and compares them as the DUT shifts them out.
module tb_startup_pattern_display;
  import startup_disp_pkg::*;

  localparam int PAT_W     = 16;
  localparam int NPAT      = 8;
  localparam int DIV       = 8;
  localparam int FRAME_LEN = PAT_W * 2 * DIV + DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  startup_pattern_display_if bus();

  startup_pattern_display #(
    .PAT_W (PAT_W),
    .NPAT  (NPAT),
    .ADR_W (4),
    .DIV   (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] rom_ref [0:15];
  logic [15:0] exp_q[$];

  int cyc       = 0;
  int abort_cyc = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // LED chain monitor: rebuild each frame from SDAT at SCLK rises, compare at LATCH.
  initial begin
    logic        sclk_p, latch_p, busy_p;
    logic [15:0] got;
    int          fstart, nbits;
    sclk_p = 1'b0; latch_p = 1'b0; busy_p = 1'b0; got = '0; fstart = 0; nbits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sclk_p = 1'b0; latch_p = 1'b0; busy_p = 1'b0; nbits = 0;
      end else begin
        if (cyc == abort_cyc || (bus.busy && !busy_p)) begin
          fstart = cyc; nbits = 0; got = '0;
        end
        if (bus.led_sclk && !sclk_p) begin
          chk("sclk_rise_cycle", cyc - fstart, DIV + 2 * DIV * nbits);
          got = {got[14:0], bus.led_sdat};
          nbits++;
        end
        if (bus.led_latch && !latch_p) begin
          chk("latch_rise_cycle", cyc - fstart, 2 * DIV * PAT_W);
          chk("frame_bit_count", nbits, PAT_W);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%0h required=no_frame", got);
          end else begin
            chk("frame_data", got, exp_q.pop_front());
          end
        end
        if (!bus.led_latch && latch_p) chk("latch_fall_cycle", cyc - fstart, FRAME_LEN);
        if (!bus.busy && busy_p)       chk("busy_frame_len", cyc - fstart, FRAME_LEN);
        sclk_p  = bus.led_sclk;
        latch_p = bus.led_latch;
        busy_p  = bus.busy;
      end
    end
  end

  // Reference model of the sequencer-visible state.
  int   m_adr, m_tmr, m_left, since_adr;
  logic m_done, m_ovr, m_oe_b, m_clr_p;
  logic clr_v, disp_v, rtmr_v;

  task automatic step(input logic nxt, input logic load);
    logic start;
    bus.nxt_adr  = nxt;
    bus.load_pat = load;
    bus.clear    = clr_v;
    bus.disp     = disp_v;
    bus.rst_tmr  = rtmr_v;
    start = 1'b0;
    if (clr_v && !m_clr_p) begin
      if (m_left > 0) begin
        void'(exp_q.pop_back());
        abort_cyc = cyc + 1;
      end
      exp_q.push_back(16'h0000);
      start = 1'b1;
    end else if (load && !clr_v && m_left == 0) begin
      exp_q.push_back(rom_ref[m_adr]);
      start = 1'b1;
    end
    if (load && m_left > 0) m_ovr = 1'b1;
    m_left = start ? FRAME_LEN : ((m_left > 0) ? m_left - 1 : 0);
    m_done = (m_adr == NPAT);
    if (clr_v)                    m_adr = 0;
    else if (nxt && m_adr < NPAT) m_adr++;
    since_adr = (nxt || clr_v) ? 0 : since_adr + 1;
    m_clr_p = clr_v;
    m_oe_b  = ~disp_v;
    m_tmr   = rtmr_v ? 0 : ((m_tmr == 65535) ? 65535 : m_tmr + 1);
    @(posedge clk);
    #1;
    bus.nxt_adr  = 1'b0;
    bus.load_pat = 1'b0;
    chk("tmr", bus.tmr, m_tmr);
    chk("done", bus.done, m_done);
    chk("busy", bus.busy, m_left > 0);
    chk("overrun", bus.overrun, m_ovr);
    chk("oe_b", bus.led_oe_b, m_oe_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    while (m_left > 0) step(1'b0, 1'b0);
  endtask

  task automatic do_load();
    while (since_adr < 1) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tmr"},   bus.tmr, 16'h0);
    chk({tag, "_done"},  bus.done, 1'b0);
    chk({tag, "_busy"},  bus.busy, 1'b0);
    chk({tag, "_ovr"},   bus.overrun, 1'b0);
    chk({tag, "_sclk"},  bus.led_sclk, 1'b0);
    chk({tag, "_sdat"},  bus.led_sdat, 1'b0);
    chk({tag, "_latch"}, bus.led_latch, 1'b0);
    chk({tag, "_oe_b"},  bus.led_oe_b, 1'b1);
  endtask

  task automatic model_reset();
    m_adr = 0; m_tmr = 0; m_left = 0; since_adr = 0;
    m_done = 1'b0; m_ovr = 1'b0; m_oe_b = 1'b1; m_clr_p = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rom_ref = '{16'h0000, 16'hA5C3, 16'h0F0F, 16'hF00F, 16'h3C3C, 16'h8001, 16'hFFFF, 16'h5A5A,
                16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    clr_v = 1'b0; disp_v = 1'b0; rtmr_v = 1'b0;
    bus.clear = 1'b0; bus.disp = 1'b0; bus.rst_tmr = 1'b0;
    bus.nxt_adr = 1'b0; bus.load_pat = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Timer runs to the dwell count, then RST_TMR zeroes it on the next CLK.
    idle(3000);
    chk("tmr_at_3000", bus.tmr, 16'hBB8);
    rtmr_v = 1'b1;
    step(1'b0, 1'b0);
    chk("tmr_held_zero", bus.tmr, 16'h0);
    rtmr_v = 1'b0;

    // First pattern, then the remaining seven; DONE rises one CLK after the 8th NXT_ADR.
    step(1'b1, 1'b0);
    do_load();
    wait_idle();
    for (int p = 2; p <= NPAT; p++) begin
      step(1'b1, 1'b0);
      if (p == NPAT) begin
        chk("done_at_nxt_edge", bus.done, 1'b0);
        step(1'b0, 1'b0);
        chk("done_one_clk_later", bus.done, 1'b1);
        step(1'b0, 1'b1);
      end else begin
        do_load();
      end
      wait_idle();
    end
    step(1'b1, 1'b0);
    do_load();
    idle(100);
    step(1'b0, 1'b1);
    chk("overrun_set", bus.overrun, 1'b1);
    wait_idle();
    idle(40);

    // CLEAR mid-frame: blank frame replaces the current one, address rewinds.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    do_load();
    idle(70);
    clr_v = 1'b1;
    idle(4);
    chk("done_after_clear", bus.done, 1'b0);
    clr_v = 1'b0;
    wait_idle();
    step(1'b1, 1'b0);
    do_load();
    wait_idle();

    disp_v = 1'b1;
    step(1'b0, 1'b0);
    chk("oe_b_on", bus.led_oe_b, 1'b0);
    disp_v = 1'b0;
    step(1'b0, 1'b0);
    chk("oe_b_off", bus.led_oe_b, 1'b1);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 8))
        0, 1, 2: begin
          if ($urandom_range(0, 1) == 1) wait_idle();
          repeat ($urandom_range(0, 2)) step(1'b1, 1'b0);
          do_load();
        end
        3: begin
          if (m_left == 0) do_load();
          idle($urandom_range(1, 200));
          step(1'b0, 1'b1);
        end
        4: begin
          if (m_left > 0 && m_left <= DIV + 4) wait_idle();
          clr_v = 1'b1;
          idle($urandom_range(1, 5));
          clr_v = 1'b0;
          step(1'b0, 1'b0);
        end
        5: begin
          disp_v = 1'($urandom_range(0, 1));
          step(1'b0, 1'b0);
        end
        6: begin
          rtmr_v = 1'b1;
          idle($urandom_range(1, 3));
          rtmr_v = 1'b0;
        end
        default: idle($urandom_range(1, 300));
      endcase
    end
    wait_idle();

    // Reset in the middle of a shift takes effect without waiting for a clock.
    disp_v = 1'b1;
    step(1'b1, 1'b0);
    do_load();
    idle(50);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_frame_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    disp_v = 1'b0;
    idle(20);
    step(1'b1, 1'b0);
    do_load();
    wait_idle();

    // Timer saturates at all-ones.
    for (int i = 0; i < 70000 && m_tmr != 65535; i++) step(1'b0, 1'b0);
    idle(5);
    chk("tmr_saturated", bus.tmr, 16'hFFFF);

    chk("frames_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
